batchnorm_stats_collector: RTL and testbench

Producer side of the batchnorm parameter interface. Accumulates a stream of fixed-point activations for one channel over 2^LOG2_N samples, then computes the mean and the biased variance. It presents these as held mean/variance words for the downstream normalizer's mean/variance inputs. Sits between the first-layer convolution output stream and the normalizer's parameter inputs.

---
 rtl/batchnorm_stats_collector_pkg.sv | 24 ++
 rtl/batchnorm_stats_collector_if.sv | 13 +
 rtl/batchnorm_stats_collector_accum.sv | 41 ++++
 rtl/batchnorm_stats_collector.sv | 137 +++++++++++++
 tb/tb_batchnorm_stats_collector.sv | 131 +++++++++++++
 5 files changed

// File: rtl/batchnorm_stats_collector_pkg.sv
// bn_pkg: shared FSM states, fixed-point constants and the variance saturation helper.
// State S_UPDATE exists only when BN_STATS_RUNNING_EN is defined.
package bn_pkg;
  localparam int BN_WIDTH = 16;
  localparam int BN_FRAC = 8;
  localparam int ONE_FP = 1 << BN_FRAC;
  localparam int VAR_MAX = (1 << (BN_WIDTH - 1)) - 1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_MEAN,
    S_SQ,
    S_VAR,
`ifdef BN_STATS_RUNNING_EN
    S_UPDATE,
`endif
    S_DONE
  } state_t;
  function automatic logic [63:0] sat_nonneg(input logic signed [63:0] d, input int w = BN_WIDTH);
    logic signed [63:0] m;
    m = (64'sd1 <<< (w - 1)) - 64'sd1;
    return d < 0 ? '0 : d > m ? m : d;
  endfunction
endpackage

// File: rtl/batchnorm_stats_collector_if.sv
// batchnorm_stats_collector_if: sample stream in, held mean/variance words out.
interface batchnorm_stats_collector_if #(parameter int WIDTH = 16);
  logic start;
  logic valid_in;
  logic signed [WIDTH-1:0] x_in;
  logic ready_in;
  logic signed [WIDTH-1:0] mean_out;
  logic [WIDTH-1:0] var_out;
  logic stats_valid;
  logic busy;
  modport master(output start, valid_in, x_in, input ready_in, mean_out, var_out, stats_valid, busy);
  modport slave(input start, valid_in, x_in, output ready_in, mean_out, var_out, stats_valid, busy);
endinterface

// File: rtl/batchnorm_stats_collector_accum.sv
// bn_stats_accum: sum / sum-of-squares accumulators and batch sample counter.
module bn_stats_accum #(
  parameter int WIDTH = 16,
  parameter int LOG2_N = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear_i,
  input  logic                                accept_i,
  input  logic signed [WIDTH-1:0]             x_i,
  output logic signed [WIDTH+LOG2_N-1:0]      sum_o,
  output logic [2*WIDTH+LOG2_N-1:0]           sumsq_o,
  output logic                                last_o
);
  localparam int SW = WIDTH + LOG2_N;
  localparam int QW = 2 * WIDTH + LOG2_N;
  logic signed [SW-1:0] sum_q, sum_d;
  logic [QW-1:0] sumsq_q, sumsq_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic signed [2*WIDTH-1:0] sq;
  always_comb begin
    sq = x_i * x_i;
    sum_d = clear_i ? '0 : accept_i ? sum_q + SW'(x_i) : sum_q;
    sumsq_d = clear_i ? '0 : accept_i ? sumsq_q + QW'($unsigned(sq)) : sumsq_q;
    cnt_d = clear_i ? '0 : accept_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      sumsq_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      sumsq_q <= sumsq_d;
      cnt_q <= cnt_d;
    end
  end
  assign sum_o = sum_q;
  assign sumsq_o = sumsq_q;
  assign last_o = accept_i && (cnt_q == '1);
endmodule

// File: rtl/batchnorm_stats_collector.sv
// batchnorm_stats_collector: per-channel batch mean and biased variance for the normalizer.
// BN_STATS_RUNNING_EN adds an UPDATE state that blends each batch into running statistics.
module batchnorm_stats_collector
  import bn_pkg::*;
#(
  parameter int WIDTH = BN_WIDTH,
  parameter int FRAC = BN_FRAC,
  parameter int LOG2_N = 8,
  parameter int MOM_SHIFT = 3
) (
  input logic clk,
  input logic rst,
  batchnorm_stats_collector_if.slave bus
);
  localparam int SW = WIDTH + LOG2_N;
  localparam int QW = 2 * WIDTH + LOG2_N;
  localparam int PW = 2 * WIDTH + 2;
  localparam logic [QW-1:0] HALF_Q = QW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] HALF_P = PW'(1) <<< (FRAC - 1);
  state_t state_q, state_d;
  logic signed [SW-1:0] sum;
  logic [QW-1:0] sumsq;
  logic last, accept;
  logic signed [WIDTH-1:0] mean_q, mean_d, mean_out_q, mean_out_d;
  logic signed [PW-1:0] ex2_q, ex2_d, msq_q, msq_d, diff;
  logic [WIDTH-1:0] var_new, var_out_q, var_out_d;
  logic stats_valid_q, stats_valid_d;
`ifdef BN_STATS_RUNNING_EN
  logic [WIDTH-1:0] var_q, var_d;
  logic first_q, first_d;
  logic signed [WIDTH:0] dmean, dvar, var_run;
  logic signed [WIDTH-1:0] mean_run;
`endif
  assign accept = bus.valid_in && state_q == S_ACCUM && !bus.start;
  bn_stats_accum #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) u_accum (
    .clk(clk),
    .rst(rst),
    .clear_i(bus.start),
    .accept_i(accept),
    .x_i(bus.x_in),
    .sum_o(sum),
    .sumsq_o(sumsq),
    .last_o(last)
  );
  assign diff = ex2_q - msq_q;
  assign var_new = WIDTH'(sat_nonneg(64'(diff), WIDTH));
`ifdef BN_STATS_RUNNING_EN
  // Momentum blend: r + ((new - r) >>> MOM_SHIFT), one guard bit keeps the difference exact
  assign dmean = {mean_q[WIDTH-1], mean_q} - {mean_out_q[WIDTH-1], mean_out_q};
  assign mean_run = mean_out_q + WIDTH'(dmean >>> MOM_SHIFT);
  assign dvar = {1'b0, var_q} - {1'b0, var_out_q};
  assign var_run = $signed({1'b0, var_out_q}) + (dvar >>> MOM_SHIFT);
`endif
  always_comb begin
    state_d = state_q;
    mean_d = mean_q;
    ex2_d = ex2_q;
    msq_d = msq_q;
    mean_out_d = mean_out_q;
    var_out_d = var_out_q;
    stats_valid_d = stats_valid_q;
`ifdef BN_STATS_RUNNING_EN
    var_d = var_q;
    first_d = first_q;
`endif
    case (state_q)
      S_ACCUM: state_d = last ? S_MEAN : S_ACCUM;
      S_MEAN: begin
        mean_d = WIDTH'(sum >>> LOG2_N);
        state_d = S_SQ;
      end
      S_SQ: begin
        ex2_d = PW'(((sumsq >> LOG2_N) + HALF_Q) >> FRAC);
        msq_d = (PW'(mean_q) * PW'(mean_q) + HALF_P) >>> FRAC;
        state_d = S_VAR;
      end
`ifdef BN_STATS_RUNNING_EN
      S_VAR: begin
        var_d = var_new;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        mean_out_d = first_q ? mean_q : mean_run;
        var_out_d = first_q ? var_q : WIDTH'(sat_nonneg(64'(var_run), WIDTH));
        first_d = 1'b0;
        stats_valid_d = 1'b1;
        state_d = S_DONE;
      end
`else
      S_VAR: begin
        mean_out_d = mean_q;
        var_out_d = var_new;
        stats_valid_d = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_IDLE, S_DONE: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
    if (bus.start) begin
      state_d = S_ACCUM;
      stats_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mean_q <= '0;
      ex2_q <= '0;
      msq_q <= '0;
      mean_out_q <= '0;
      var_out_q <= '0;
      stats_valid_q <= 1'b0;
`ifdef BN_STATS_RUNNING_EN
      var_q <= '0;
      first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      mean_q <= mean_d;
      ex2_q <= ex2_d;
      msq_q <= msq_d;
      mean_out_q <= mean_out_d;
      var_out_q <= var_out_d;
      stats_valid_q <= stats_valid_d;
`ifdef BN_STATS_RUNNING_EN
      var_q <= var_d;
      first_q <= first_d;
`endif
    end
  end
  assign bus.ready_in = state_q == S_ACCUM;
  assign bus.busy = !(state_q == S_IDLE || state_q == S_DONE);
  assign bus.mean_out = mean_out_q;
  assign bus.var_out = var_out_q;
  assign bus.stats_valid = stats_valid_q;
endmodule

// File: tb/tb_batchnorm_stats_collector.sv
// tb_batchnorm_stats_collector: directed batches of 4 samples with hand-computed statistics.
// Define BN_STATS_RUNNING_EN to also exercise the running-average update.
module tb_batchnorm_stats_collector;
  import bn_pkg::*;
`ifdef BN_STATS_RUNNING_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  batchnorm_stats_collector_if #(.WIDTH(16)) bus ();
  batchnorm_stats_collector #(.WIDTH(16), .FRAC(8), .LOG2_N(2), .MOM_SHIFT(1)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
  endtask
  task automatic feed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    logic [15:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      bus.x_in = v[i];
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
  endtask
  task automatic batch(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d, input logic [15:0] em, input logic [15:0] ev);
    pulse_start();
    feed(a, b, c, d);
    repeat (LAT - 1) @(negedge clk);
    check({tag, "_valid_early"}, 16'(bus.stats_valid), 16'd0);
    @(negedge clk);
    check({tag, "_valid"}, 16'(bus.stats_valid), 16'd1);
    check({tag, "_mean"}, bus.mean_out, em);
    check({tag, "_var"}, bus.var_out, ev);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    bus.x_in = '0;
    do_reset();
    check("rst_mean", bus.mean_out, 16'h0000);
    check("rst_var", bus.var_out, 16'h0000);
    check("rst_valid", 16'(bus.stats_valid), 16'd0);
    check("rst_ready", 16'(bus.ready_in), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    batch("const", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'(ONE_FP), 16'h0000);
    check("done_busy", 16'(bus.busy), 16'd0);
    do_reset();
    batch("twolvl", 16'h0000, 16'h0200, 16'h0000, 16'h0200, 16'h0100, 16'h0100);
    do_reset();
    batch("signed", 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'h0000, 16'h0100);
    do_reset();
    batch("sat", 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'(VAR_MAX));
    do_reset();
    bus.valid_in = 1'b1;
    bus.x_in = 16'h7FFF;
    repeat (3) @(negedge clk);
    check("idle_ready", 16'(bus.ready_in), 16'd0);
    check("idle_busy", 16'(bus.busy), 16'd0);
    bus.valid_in = 1'b0;
    batch("idle_ign", 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0000);
    do_reset();
    pulse_start();
    check("accum_ready", 16'(bus.ready_in), 16'd1);
    bus.valid_in = 1'b1;
    bus.x_in = 16'h4000;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_in = 16'h0000;
    bus.valid_in = 1'b0;
    check("restart_valid", 16'(bus.stats_valid), 16'd0);
    feed(16'h0000, 16'h0200, 16'h0000, 16'h0200);
    repeat (LAT - 1) @(negedge clk);
    check("restart_early", 16'(bus.stats_valid), 16'd0);
    @(negedge clk);
    check("restart_done", 16'(bus.stats_valid), 16'd1);
    check("restart_mean", bus.mean_out, 16'h0100);
    check("restart_var", bus.var_out, 16'h0100);
    pulse_start();
    feed(16'h0300, 16'h0300, 16'h0300, 16'h0300);
    @(negedge clk);
    check("sq_busy", 16'(bus.busy), 16'd1);
    check("sq_valid", 16'(bus.stats_valid), 16'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_mean", bus.mean_out, 16'h0000);
    check("arst_var", bus.var_out, 16'h0000);
    check("arst_busy", 16'(bus.busy), 16'd0);
    check("arst_ready", 16'(bus.ready_in), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_idle", 16'(bus.stats_valid), 16'd0);
`ifdef BN_STATS_RUNNING_EN
    do_reset();
    batch("run1", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
    batch("run2", 16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0200, 16'h0000);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
